// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM encoding, port indices and defaults for the data-memory arbiter
package dmem_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
   localparam int P_CORE = 0;
   localparam int P_LOAD = 1;
   localparam int DEPTH_DEF = 10001;
   localparam int LOCK_MAX_DEF = 16;
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; on a tie the port opposite the last grant wins
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [1:0] mask,
   input  logic       upd,
   output logic [1:0] gnt
);
   logic       ptr;
   logic [1:0] act;
   assign act = req & mask;
   assign gnt = (&act) ? (ptr ? 2'b01 : 2'b10) : act;
   always_ff @(posedge clk)
      if (rst) ptr <= 1'b1;
      else if (upd) ptr <= gnt[P_LOAD];
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one word-addressed data memory between the core and loader ports
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int DEPTH = DEPTH_DEF,
   parameter int LOCK_MAX = LOCK_MAX_DEF
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic          lock0,
   input  logic          lock1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          err0,
   output logic          err1,
   output logic [AW-1:0] mem_a,
   output logic [DW-1:0] mem_wd,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rd
);
   localparam int CW = $clog2(LOCK_MAX + 1);
   localparam logic [AW-1:0] LIM = AW'(DEPTH);
   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n, cnt_inc;
   logic [1:0]    req, lock, we, ok, mask, arb_gnt, gnt;
   logic          own;
   assign req = {req1, req0};
   assign lock = {lock1, lock0};
   assign we = {we1, we0};
   assign ok = {addr1 < LIM, addr0 < LIM};
   assign mask = (state == OWN0) ? 2'b01 : (state == OWN1) ? 2'b10 : 2'b11;
   rr_arb2 u_arb (.clk, .rst, .req, .mask, .upd(|gnt), .gnt(arb_gnt));
   assign gnt = rst ? 2'b00 : arb_gnt;
   assign {gnt1, gnt0} = gnt;
   assign own = (state == OWN1);
   assign cnt_inc = cnt + 1'b1;
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      if (state == IDLE) begin
         if (LOCK_MAX > 1 && |(gnt & lock)) begin
            state_n = gnt[P_LOAD] ? OWN1 : OWN0;
            cnt_n = CW'(1);
         end
      end else if (state != OWN0 && state != OWN1) begin
         state_n = IDLE;
         cnt_n = '0;
      end else if (!req[own] || (gnt[own] && (!lock[own] || cnt_inc >= CW'(LOCK_MAX)))) begin
         state_n = IDLE;
         cnt_n = '0;
      end else if (gnt[own]) begin
         cnt_n = cnt_inc;
      end
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
      end
   // out-of-range writes are masked so they never reach the array
   assign mem_a = gnt[P_CORE] ? addr0 : gnt[P_LOAD] ? addr1 : '0;
   assign mem_wd = gnt[P_CORE] ? wdata0 : gnt[P_LOAD] ? wdata1 : '0;
   assign mem_we = |(gnt & we & ok);
   always_ff @(posedge clk)
      if (rst) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         err0 <= 1'b0;
         err1 <= 1'b0;
         rdata0 <= '0;
         rdata1 <= '0;
      end else begin
         rvalid0 <= gnt[P_CORE];
         rvalid1 <= gnt[P_LOAD];
         err0 <= gnt[P_CORE] & ~ok[P_CORE];
         err1 <= gnt[P_LOAD] & ~ok[P_LOAD];
         rdata0 <= (gnt[P_CORE] & ~we[P_CORE] & ok[P_CORE]) ? mem_rd : '0;
         rdata1 <= (gnt[P_LOAD] & ~we[P_LOAD] & ok[P_LOAD]) ? mem_rd : '0;
      end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random stimulus checked against a behavioural arbiter model
module tb_dmem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int DEPTH = 10001;
   localparam int LOCK_MAX = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tr[2], tw[2], tl[2];
   logic [AW-1:0] ta[2];
   logic [DW-1:0] td[2];
   logic gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we;
   logic [DW-1:0] rdata0, rdata1, mem_wd, mem_rd;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] env_mem [0:DEPTH-1];
   logic [DW-1:0] mm [0:DEPTH-1];
   bit loaded, minit, armed;
   bit mg[2];
   int n_chk, n_pass;
   int owner = -1, beats, last = 1, g;
   bit e_rv[2], e_er[2];
   logic [DW-1:0] e_rd[2];
   logic [AW-1:0] ea;
   logic [DW-1:0] ed;
   logic ewe;
   int beats1;
   bit seen0;
   dmem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .rst(rst),
      .req0(tr[0]), .req1(tr[1]), .we0(tw[0]), .we1(tw[1]),
      .lock0(tl[0]), .lock1(tl[1]), .addr0(ta[0]), .addr1(ta[1]),
      .wdata0(td[0]), .wdata1(td[1]), .gnt0(gnt0), .gnt1(gnt1),
      .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
      .err0(err0), .err1(err1), .mem_a(mem_a), .mem_wd(mem_wd),
      .mem_we(mem_we), .mem_rd(mem_rd)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] f(int i);
      return (32'(i) * 32'h9E3779B1) ^ 32'h0000_5A5A;
   endfunction
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask
   task automatic setp(input int p, input logic r, input logic w, input logic l,
                       input logic [31:0] a, input logic [31:0] d);
      tr[p] = r;
      tw[p] = w;
      tl[p] = l;
      ta[p] = a;
      td[p] = d;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   always @(posedge clk)
      if (!loaded) begin
         for (int i = 0; i < DEPTH; i++) env_mem[i] <= f(i);
         loaded <= 1'b1;
      end else if (mem_we && mem_a < DEPTH) begin
         env_mem[mem_a] <= mem_wd;
      end
   always_comb mem_rd = (mem_a < DEPTH) ? env_mem[mem_a] : '0;
   // reference model: owner/beat bookkeeping evaluated from the arbitration rules each cycle
   always @(negedge clk) begin
      if (!minit) begin
         for (int i = 0; i < DEPTH; i++) mm[i] = f(i);
         minit = 1'b1;
      end
      if (armed) begin
         chk("resp0", {rvalid0, err0, rdata0}, {e_rv[0], e_er[0], e_rd[0]});
         chk("resp1", {rvalid1, err1, rdata1}, {e_rv[1], e_er[1], e_rd[1]});
      end
      g = -1;
      if (!rst) begin
         if (owner >= 0) g = tr[owner] ? owner : -1;
         else if (tr[0] && tr[1]) g = 1 - last;
         else if (tr[0]) g = 0;
         else if (tr[1]) g = 1;
      end
      ea = (g >= 0) ? ta[g] : '0;
      ed = (g >= 0) ? td[g] : '0;
      ewe = (g >= 0) && tw[g] && (ta[g] < DEPTH);
      chk("comb", {gnt0, gnt1, mem_we, mem_a, mem_wd}, {g == 0, g == 1, ewe, ea, ed});
      for (int p = 0; p < 2; p++) begin
         e_rv[p] = (g == p);
         e_er[p] = (g == p) && (ta[p] >= DEPTH);
         e_rd[p] = ((g == p) && !tw[p] && ta[p] < DEPTH) ? mm[ta[p]] : '0;
      end
      if (ewe) mm[ta[g]] = td[g];
      if (rst) begin
         owner = -1;
         beats = 0;
         last = 1;
      end else if (g >= 0) begin
         last = g;
         if (owner < 0) begin
            if (tl[g]) begin
               owner = g;
               beats = 1;
            end
         end else begin
            beats++;
            if (!tl[g] || beats == LOCK_MAX) owner = -1;
         end
      end else if (owner >= 0) begin
         owner = -1;
      end
      mg[0] = (g == 0);
      mg[1] = (g == 1);
      armed = armed | rst;
   end
   initial begin
      setp(0, 0, 0, 0, 0, 0);
      setp(1, 0, 0, 0, 0, 0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_rvalid", {rvalid0, rvalid1, gnt0, gnt1}, 4'b0000);
      tick();
      setp(0, 1, 1, 0, 32'h10, 32'hDEADBEEF);
      @(negedge clk);
      chk("t1_wr_gnt", gnt0, 1'b1);
      tick();
      setp(0, 1, 0, 0, 32'h10, 0);
      @(negedge clk);
      chk("t1_rd_gnt", {gnt0, rvalid0, err0, rdata0}, {1'b1, 1'b1, 1'b0, 32'h0});
      tick();
      setp(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t1_rdata", {rvalid0, err0, rdata0}, {1'b1, 1'b0, 32'hDEADBEEF});
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         setp(0, c < 4, 0, 0, 5, 0);
         setp(1, c < 4, 0, 0, 6, 0);
         @(negedge clk);
         if (c < 4) chk("t2_gnt", {gnt1, gnt0}, (c % 2 == 0) ? 2'b01 : 2'b10);
         if (c > 0 && c % 2 == 1) chk("t2_rd0", {rvalid0, rdata0}, {1'b1, f(5)});
         if (c > 0 && c % 2 == 0) chk("t2_rd1", {rvalid1, rdata1}, {1'b1, f(6)});
         tick();
      end
      for (int c = 0; c < 5; c++) begin
         setp(1, c < 4, 1, c < 3, 100 + c, c + 1);
         setp(0, c >= 1, 0, 0, 7, 0);
         @(negedge clk);
         chk("t3_gnt", {gnt1, gnt0}, (c < 4) ? 2'b10 : 2'b01);
         tick();
      end
      setp(0, 0, 0, 0, 0, 0);
      tick();
      for (int k = 0; k < 4; k++) chk("t3_mem", env_mem[100 + k], k + 1);
      beats1 = 0;
      seen0 = 1'b0;
      for (int c = 0; c < 40 && !seen0; c++) begin
         setp(0, 1, 0, 0, 8, 0);
         setp(1, 1, 1, 1, 200 + c, c);
         @(negedge clk);
         if (gnt0) seen0 = 1'b1;
         else if (gnt1) beats1++;
         tick();
      end
      chk("t4_beats", beats1, LOCK_MAX);
      chk("t4_release", seen0, 1'b1);
      setp(0, 0, 0, 0, 0, 0);
      setp(1, 0, 0, 0, 0, 0);
      tick();
      setp(0, 1, 0, 0, DEPTH, 0);
      @(negedge clk);
      chk("t5_gnt", gnt0, 1'b1);
      tick();
      setp(0, 1, 1, 0, DEPTH, 32'h55);
      @(negedge clk);
      chk("t5_oor_rd", {mem_we, rvalid0, err0, rdata0}, {1'b0, 1'b1, 1'b1, 32'h0});
      tick();
      setp(0, 1, 1, 0, DEPTH - 1, 32'h77);
      @(negedge clk);
      chk("t5_oor_wr", {mem_we, rvalid0, err0, rdata0}, {1'b1, 1'b1, 1'b1, 32'h0});
      tick();
      setp(0, 1, 0, 0, DEPTH - 1, 0);
      @(negedge clk);
      chk("t5_edge_wr", {rvalid0, err0}, 2'b10);
      tick();
      setp(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t5_edge_rd", {rvalid0, err0, rdata0}, {1'b1, 1'b0, 32'h77});
      tick();
      setp(1, 1, 0, 1, 300, 0);
      tick();
      setp(0, 1, 0, 0, 9, 0);
      setp(1, 1, 0, 1, 301, 0);
      @(negedge clk);
      chk("t6_own", {gnt1, gnt0}, 2'b10);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst", {gnt1, gnt0, rvalid1}, 3'b001);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_after", {rvalid1, gnt0, gnt1}, 3'b010);
      tick();
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 249) == 0);
         for (int p = 0; p < 2; p++)
            if (!(tr[p] && !mg[p]))
               setp(p, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 9) < 4,
                    ($urandom_range(0, 3) == 0) ? 32'(DEPTH - 2) + $urandom_range(0, 3)
                                                : $urandom_range(0, 31),
                    $urandom);
         tick();
      end
      rst = 1'b0;
      setp(0, 0, 0, 0, 0, 0);
      setp(1, 0, 0, 0, 0, 0);
      repeat (3) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single-port word-addressed data memory.
- Requester 0 is the core load/store path; requester 1 is the test/loader port (program/data preload, debug peek/poke).
- Grants one access per cycle with round-robin fairness and an optional bounded lock for multi-word bursts.
- Drives the memory A/WD/WE pins and returns registered read data with a range-error flag.

Parameters:
- AW, 32, address width (word address).
- DW, 32, data width.
- DEPTH, 10001, number of implemented memory words; legal addresses are 0..DEPTH-1.
- LOCK_MAX, 16, maximum consecutive locked grants before forced release.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read
- lock0 / lock1  in  1  keep ownership after this grant
- addr0 / addr1  in  AW  word address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  combinational grant; transfer occurs when req & gnt
- rvalid0 / rvalid1  out  1  response strobe, one cycle after the transfer
- rdata0 / rdata1  out  DW  read data; 0 for writes and errors
- err0 / err1  out  1  out-of-range access, valid with rvalid
- mem_a  out  AW  to memory A
- mem_wd  out  DW  to memory WD
- mem_we  out  1  to memory WE
- mem_rd  in  DW  from memory RD (combinational read)

Behaviour:
- Reset values:
  - Registered outputs: rvalid*, err*, rdata* = 0.
  - Internal state: state = IDLE, last-granted pointer = 1 (port 0 wins first tie), lock count = 0.
  - Combinational outputs while rst is high: gnt*, mem_we = 0; mem_a, mem_wd = 0.
- Grant and mux rules:
  - At most one gnt per cycle; gnt0 & gnt1 is never 1.
  - The granted port's addr/wdata drive mem_a/mem_wd. When idle, mem_a/mem_wd = 0.
  - mem_we = gnt_i & we_i & (addr_i < DEPTH). An out-of-range write never reaches memory.
- Response, latency 1:
  - The cycle after a transfer on port i: rvalid_i = 1.
  - rdata_i = registered mem_rd for an in-range read, else 0.
  - err_i = (addr_i >= DEPTH).
  - Back-to-back transfers give back-to-back responses, in order.
- FSM states IDLE, OWN0, OWN1:
  - IDLE:
    - Single requester is granted.
    - Both requesting: grant the port not equal to the last-granted pointer.
    - A grant with lock_i = 1 moves to OWN_i and sets lock count = 1.
  - OWN_i:
    - Only port i may be granted, even if port j requests.
    - Each granted beat increments lock count.
    - Return to IDLE when a grant occurs with lock_i = 0, or when req_i = 0.
    - Forced release: when lock count reaches LOCK_MAX, return to IDLE regardless of lock_i, and set the pointer so port j wins the next tie.
  - Pointer updates to i on every grant to i.
- Boundaries:
  - A simultaneous request from the owner's rival during OWN is stalled, not dropped.
  - Lock asserted with an out-of-range address still takes ownership; err is reported per beat.
  - Address exactly DEPTH-1 is legal; DEPTH is err.
  - rst mid-burst: ownership, pointer and any pending response are cleared on the next edge. No rvalid follows a transfer that coincides with a reset cycle.

Decomposition:
- Package dmem_arb_pkg:
  - FSM state encoding (IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2).
  - Port index constants P_CORE = 0, P_LOAD = 1.
  - Default DEPTH and LOCK_MAX.
- One natural sub-module, rr_arb2: two-input round-robin arbiter holding the last-granted pointer. Inputs: req vector, force-mask, update enable. Output: one-hot grant.
- Lock FSM, response registers and the memory mux stay in dmem_arbiter.

Test Plan:
- Port 0 only: write 0xDEADBEEF to addr 0x10, then read 0x10 → gnt0 same cycle; rvalid0 one cycle after each transfer; read rdata0 = 0xDEADBEEF, err0 = 0.
- Both ports request reads (addr 5 / addr 6) continuously for 4 cycles out of reset → grants alternate 0,1,0,1; responses carry mem[5] and mem[6] respectively.
- Port 1 locks a 4-beat burst writing 0x1..0x4 to addr 100..103 while port 0 requests → gnt1 for 4 cycles, gnt0 on cycle 5; memory holds 1,2,3,4.
- Port 1 holds lock1 = 1 with LOCK_MAX = 16 while port 0 requests → exactly 16 gnt1 beats, then gnt0.
- Read addr 10001 and write 0x55 to addr 10001 → err = 1 with rvalid, rdata = 0, mem_we never 1; addr 10000 succeeds with err = 0.
- Assert rst for one cycle during an OWN1 burst with a read in flight → no rvalid1 afterwards; next tied request grants port 0.
